// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CNT_W = 5;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring shift-subtract divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               div_mode,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // Partial remainder after the left shift needs one extra bit of headroom.
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh[WIDTH-1:0] - operand;
    q_bit    = 1'b0;
    acc_next = '0;
    if (div_mode) begin
      q_bit    = (rem_sh >= {1'b0, operand});
      acc_next = {(q_bit ? diff : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS MULT/MULTU/DIV/DIVU sequencer owning HI/LO; 33-cycle latency per op.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               div_q, div_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               div0_q, div0_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               is_signed;
  logic               is_div;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] step_acc;
  logic               step_q;
  logic [2*WIDTH-1:0] prod_fix;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .operand  (opnd_q),
    .div_mode (div_q),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    is_div    = (op == OP_DIV) || (op == OP_DIVU);
    abs_a     = (is_signed && A[WIDTH-1]) ? -A : A;
    abs_b     = (is_signed && B[WIDTH-1]) ? -B : B;
    prod_fix  = (sa_q ^ sb_q) ? -acc_q : acc_q;
  end

  // Next-state, datapath and HI/LO update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    a_raw_d = a_raw_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    div0_d  = div0_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (!flush) begin
            a_raw_d = A;
            div_d   = is_div;
            sa_d    = is_signed & A[WIDTH-1];
            sb_d    = is_signed & B[WIDTH-1];
            div0_d  = (B == '0);
            acc_d   = is_div ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
            opnd_d  = is_div ? abs_b : abs_a;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end else begin
          if (wr_hi) hi_d = wdata;
          if (wr_lo) lo_d = wdata;
        end
      end
      RUN: begin
        if (flush) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          acc_d = {step_acc[2*WIDTH-1:1], step_acc[0] | step_q};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
        end
      end
      FIX: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!div_q) begin
            {hi_d, lo_d} = prod_fix;
          end else if (div0_q) begin
            hi_d = a_raw_q;
            lo_d = WIDTH'(DIV0_QUOT);
          end else begin
            lo_d = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            hi_d = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      a_raw_q <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div0_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      a_raw_q <= a_raw_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      div0_q  <= div0_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit: result values, latency, and busy-time events.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        flush;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (a_in),
    .B     (b_in),
    .flush (flush),
    .wr_hi (wr_hi),
    .wr_lo (wr_lo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op and check the full 33-cycle busy/done timeline plus results.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    logic busy_ok;
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b;
    tick();
    start = 1'b0;
    chk({name, " busy@T"}, 32'(busy), 32'd1);
    busy_ok = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (!busy || done) busy_ok = 1'b0;
    end
    chk({name, " busy T+1..T+32"}, 32'(busy_ok), 32'd1);
    tick();
    chk({name, " done@T+33"}, 32'(done), 32'd1);
    chk({name, " busy@T+33"}, 32'(busy), 32'd0);
    chk({name, " hi"}, hi, eh);
    chk({name, " lo"}, lo, el);
    tick();
    chk({name, " done@T+34"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic seen_done;

    vecs[0] = '{"multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{"mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{"div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{"divu",      2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4] = '{"divu_by0",  2'b11, 32'h0000_0064, 32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
    vecs[5] = '{"div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6] = '{"div_by0",   2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[7] = '{"mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8] = '{"div_negb",  2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[9] = '{"multu_sh",  2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};

    reset = 1'b1; start = 1'b0; op = 2'b00; a_in = '0; b_in = '0;
    flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
    repeat (3) tick();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    reset = 1'b0;
    tick();

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);

    // Second start and MTHI while busy are both ignored.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a_in = 32'd5; b_in = 32'd6;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      if (i == 5) begin start = 1'b1; a_in = 32'd1; b_in = 32'd1; end
      if (i == 6) begin wr_hi = 1'b1; wdata = 32'hDEAD_BEEF; end
      tick();
      start = 1'b0; wr_hi = 1'b0;
      if (i == 32) chk("busy_ev busy@T+32", 32'(busy), 32'd1);
    end
    chk("busy_ev done", 32'(done), 32'd1);
    chk("busy_ev hi", hi, 32'd0);
    chk("busy_ev lo", lo, 32'd30);
    tick();

    // Flush mid-run: busy drops immediately, no done, HI/LO untouched.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a_in = 32'd9; b_in = 32'd9;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    chk("flush busy", 32'(busy), 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) seen_done = 1'b1;
    end
    chk("flush no done/busy", 32'(seen_done), 32'd0);
    chk("flush hi", hi, 32'd0);
    chk("flush lo", lo, 32'd30);

    // MTHI/MTLO together in IDLE.
    @(negedge clk);
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h0000_1234;
    tick();
    wr_hi = 1'b0; wr_lo = 1'b0;
    chk("wr both hi", hi, 32'h0000_1234);
    chk("wr both lo", lo, 32'h0000_1234);

    // start+flush in IDLE: start dropped, concurrent write also ignored.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; wr_lo = 1'b1; wdata = 32'h5555_5555; op = 2'b11;
    a_in = 32'd10; b_in = 32'd3;
    tick();
    start = 1'b0; flush = 1'b0; wr_lo = 1'b0;
    chk("start+flush busy", 32'(busy), 32'd0);
    chk("start+flush lo", lo, 32'h0000_1234);
    tick();
    chk("start+flush busy later", 32'(busy), 32'd0);

    // Reset mid-divide clears everything; a fresh op then runs normally.
    @(negedge clk);
    start = 1'b1; op = 2'b10; a_in = 32'd50; b_in = 32'd5;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 20) reset = 1'b1;
      tick();
    end
    reset = 1'b0;
    chk("mid reset busy", 32'(busy), 32'd0);
    chk("mid reset done", 32'(done), 32'd0);
    chk("mid reset hi", hi, 32'd0);
    chk("mid reset lo", lo, 32'd0);
    run_op("post_reset", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
